duck_flight_ctrl: RTL and testbench

Duck trajectory generator for the hunt screen: produces `duck_xpos`/`duck_ypos` consumed by `duck_game_logic` and reacts to its `hunt_start` and hit outputs. Spawns a duck at a pseudo-random ground position, flies it with wall bounces on a slow movement tick, and ends with either a fall animation after a hit or an escape off the top edge. Sits between game logic and the duck sprite draw block.

---
 rtl/duck_pkg.sv | 21 ++
 rtl/duck_lfsr.sv | 29 ++
 rtl/duck_flight_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_duck_flight_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// duck_pkg: shared types and screen constants for the duck flight controller.
//   duck_state_t    - flight FSM states
//   H_MAX_DEF, GROUND_Y_DEF, DUCK_SIZE_DEF - default screen geometry
//   LFSR_SEED       - non-zero start value of the spawn position LFSR
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLY    = 3'd1,
    ST_HIT    = 3'd2,
    ST_FALL   = 3'd3,
    ST_ESCAPE = 3'd4
  } duck_state_t;

  localparam int H_MAX_DEF     = 1024;
  localparam int GROUND_Y_DEF  = 600;
  localparam int DUCK_SIZE_DEF = 64;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/duck_lfsr.sv
// duck_lfsr: free-running 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1).
// Advances every clock; the seed is non-zero and the polynomial is maximal,
// so the register never reaches the all-zero lock-up state.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset (loads LFSR_SEED)
//   lfsr out current 16-bit register value
module duck_lfsr
  import duck_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/duck_flight_ctrl.sv
// duck_flight_ctrl: duck trajectory generator for the hunt screen.
// Spawns a duck at a pseudo-random ground position, flies it with wall
// bounces on a slow movement tick, then either drops it after a hit or lets
// it escape off the top edge.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   game_enable     low forces IDLE (position held, no pulses)
//   hunt_start      one-cycle request for a new duck (IDLE only)
//   duck_hit        one-cycle shot notification (FLY only)
//   duck_xpos/ypos  sprite top-left corner, 12-bit
//   duck_visible    sprite draw enable
//   duck_falling    high in HIT and FALL
//   duck_dir_left   horizontal direction for sprite mirroring
//   duck_down       one-cycle pulse when the fall lands
//   duck_escaped    one-cycle pulse when the duck leaves the top edge
// Configuration macro: DUCK_SPEEDUP_EN - adds a saturating hit counter that
// raises the per-tick step by hits/2 pixels.
module duck_flight_ctrl
  import duck_pkg::*;
#(
  parameter int H_MAX           = H_MAX_DEF,
  parameter int DUCK_SIZE       = DUCK_SIZE_DEF,
  parameter int GROUND_Y        = GROUND_Y_DEF,
  parameter int MOVE_DIV        = 650_000,
  parameter int FLIGHT_TICKS    = 500,
  parameter int HIT_PAUSE_TICKS = 50,
  parameter int STEP            = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_enable,
  input  logic        hunt_start,
  input  logic        duck_hit,
  output logic [11:0] duck_xpos,
  output logic [11:0] duck_ypos,
  output logic        duck_visible,
  output logic        duck_falling,
  output logic        duck_dir_left,
  output logic        duck_down,
  output logic        duck_escaped
);

  localparam logic [11:0] X_MAX       = 12'(H_MAX - DUCK_SIZE);
  localparam logic [11:0] Y_GND       = 12'(GROUND_Y - DUCK_SIZE);
  localparam logic [11:0] STEP_BASE   = 12'(STEP);
  localparam logic [19:0] DIV_LAST    = 20'(MOVE_DIV - 1);
  localparam logic [15:0] FLIGHT_LAST = 16'(FLIGHT_TICKS - 1);
  localparam logic [15:0] PAUSE_LAST  = 16'(HIT_PAUSE_TICKS - 1);

  duck_state_t state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        dir_left_q, dir_left_d, up_q, up_d;
  logic        visible_q, visible_d, falling_q, falling_d;
  logic        down_q, down_d, escaped_q, escaped_d;
  logic [19:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] lfsr;
  logic [4:0]  unused_lfsr_hi;
  logic        tick;
  logic [11:0] step, fall_step, spawn_x;

  duck_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign unused_lfsr_hi = lfsr[15:11];
  assign tick           = (div_q == DIV_LAST);
  assign spawn_x        = ({2'b00, lfsr[9:0]} > X_MAX) ? X_MAX : {2'b00, lfsr[9:0]};

`ifdef DUCK_SPEEDUP_EN
  logic [2:0] hits_q, hits_d;
  assign step = STEP_BASE + {10'd0, hits_q[2:1]};
`else
  assign step = STEP_BASE;
`endif
  assign fall_step = {step[10:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_left_d = dir_left_q;
    up_d       = up_q;
    cnt_d      = cnt_q;
    down_d     = 1'b0;
    escaped_d  = 1'b0;
    // Divider idles at zero and free-runs in every active state.
    div_d      = (state_q == ST_IDLE || tick) ? 20'd0 : div_q + 20'd1;
`ifdef DUCK_SPEEDUP_EN
    hits_d     = hits_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (hunt_start) begin
          x_d        = spawn_x;
          y_d        = Y_GND;
          dir_left_d = lfsr[10];
          up_d       = 1'b1;
          cnt_d      = '0;
          div_d      = '0;
          state_d    = ST_FLY;
        end
      end
      ST_FLY: begin
        // A hit is taken on any clock and beats a same-tick escape.
        if (duck_hit) begin
          cnt_d   = '0;
          state_d = ST_HIT;
`ifdef DUCK_SPEEDUP_EN
          if (hits_q != 3'd6) hits_d = hits_q + 3'd1;
`endif
        end else if (tick) begin
          // Bounds are tested before the add/subtract so nothing wraps;
          // touching a wall flips the direction.
          if (dir_left_q) begin
            if (x_q <= step) begin x_d = '0; dir_left_d = 1'b0; end
            else x_d = x_q - step;
          end else begin
            if (x_q >= X_MAX - step) begin x_d = X_MAX; dir_left_d = 1'b1; end
            else x_d = x_q + step;
          end
          if (up_q) begin
            if (y_q <= step) begin y_d = '0; up_d = 1'b0; end
            else y_d = y_q - step;
          end else begin
            if (y_q >= Y_GND - step) begin y_d = Y_GND; up_d = 1'b1; end
            else y_d = y_q + step;
          end
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == FLIGHT_LAST) state_d = ST_ESCAPE;
        end
      end
      ST_HIT: begin
        if (tick) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == PAUSE_LAST) state_d = ST_FALL;
        end
      end
      ST_FALL: begin
        if (tick) begin
          if (y_q >= Y_GND - fall_step) begin
            y_d     = Y_GND;
            down_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            y_d = y_q + fall_step;
          end
        end
      end
      ST_ESCAPE: begin
        if (tick) begin
          if (y_q < step) begin
            escaped_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            y_d = y_q - step;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling the game aborts silently with the sprite position frozen.
    if (!game_enable) begin
      state_d    = ST_IDLE;
      x_d        = x_q;
      y_d        = y_q;
      dir_left_d = dir_left_q;
      up_d       = up_q;
      div_d      = '0;
      down_d     = 1'b0;
      escaped_d  = 1'b0;
`ifdef DUCK_SPEEDUP_EN
      hits_d     = hits_q;
`endif
    end

    visible_d = (state_d != ST_IDLE);
    falling_d = (state_d == ST_HIT) || (state_d == ST_FALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      dir_left_q <= 1'b0;
      up_q       <= 1'b0;
      visible_q  <= 1'b0;
      falling_q  <= 1'b0;
      down_q     <= 1'b0;
      escaped_q  <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
`ifdef DUCK_SPEEDUP_EN
      hits_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_left_q <= dir_left_d;
      up_q       <= up_d;
      visible_q  <= visible_d;
      falling_q  <= falling_d;
      down_q     <= down_d;
      escaped_q  <= escaped_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
`ifdef DUCK_SPEEDUP_EN
      hits_q     <= hits_d;
`endif
    end
  end

  assign duck_xpos     = x_q;
  assign duck_ypos     = y_q;
  assign duck_visible  = visible_q;
  assign duck_falling  = falling_q;
  assign duck_dir_left = dir_left_q;
  assign duck_down     = down_q;
  assign duck_escaped  = escaped_q;

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Directed testbench for duck_flight_ctrl with a small, fast configuration
// (MOVE_DIV=4, FLIGHT_TICKS=20, HIT_PAUSE_TICKS=3, STEP=2).
module tb_duck_flight_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_enable = 1'b0;
  logic        hunt_start = 1'b0;
  logic        duck_hit = 1'b0;
  logic [11:0] duck_xpos, duck_ypos;
  logic        duck_visible, duck_falling, duck_dir_left, duck_down, duck_escaped;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference LFSR, used to know where the next duck will spawn.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  duck_flight_ctrl #(
    .MOVE_DIV        (4),
    .FLIGHT_TICKS    (20),
    .HIT_PAUSE_TICKS (3),
    .STEP            (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .game_enable   (game_enable),
    .hunt_start    (hunt_start),
    .duck_hit      (duck_hit),
    .duck_xpos     (duck_xpos),
    .duck_ypos     (duck_ypos),
    .duck_visible  (duck_visible),
    .duck_falling  (duck_falling),
    .duck_dir_left (duck_dir_left),
    .duck_down     (duck_down),
    .duck_escaped  (duck_escaped)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic clk_step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spawn(output int ex, output int ed);
    ex = (int'(m_lfsr[9:0]) > 960) ? 960 : int'(m_lfsr[9:0]);
    ed = int'(m_lfsr[10]);
    hunt_start = 1'b1;
    clk_step(1);
    hunt_start = 1'b0;
  endtask

  task automatic wait_y(input string tag, input int val, input int bound, output int n);
    n = 0;
    while (int'(duck_ypos) != val && n < bound) begin
      clk_step(1);
      n++;
    end
    check_eq(tag, int'(duck_ypos), val);
  endtask

  initial begin
    int ex, ed, n, xh;
    int seen;

    // Reset values
    clk_step(3);
    check_eq("rst_x", int'(duck_xpos), 0);
    check_eq("rst_y", int'(duck_ypos), 0);
    check_eq("rst_vis", int'(duck_visible), 0);
    check_eq("rst_fall", int'(duck_falling), 0);
    check_eq("rst_dir", int'(duck_dir_left), 0);
    check_eq("rst_pulses", int'(duck_down) + int'(duck_escaped), 0);
    rst = 1'b0;
    game_enable = 1'b1;
    clk_step(1);

    // Hit while idle is ignored
    duck_hit = 1'b1;
    clk_step(1);
    duck_hit = 1'b0;
    check_eq("idle_hit_vis", int'(duck_visible), 0);
    check_eq("idle_hit_fall", int'(duck_falling), 0);

    // Spawn and first move
    spawn(ex, ed);
    check_eq("spawn_vis", int'(duck_visible), 1);
    check_eq("spawn_y", int'(duck_ypos), 536);
    check_eq("spawn_x", int'(duck_xpos), ex);
    check_eq("spawn_x_le960", int'(duck_xpos <= 12'd960), 1);
    check_eq("spawn_dir", int'(duck_dir_left), ed);
    clk_step(3);
    check_eq("pre_tick_y", int'(duck_ypos), 536);
    clk_step(1);
    check_eq("tick1_y", int'(duck_ypos), 534);

    // Second hunt_start while flying is ignored
    xh = int'(duck_xpos);
    hunt_start = 1'b1;
    clk_step(1);
    hunt_start = 1'b0;
    check_eq("fly_start_y", int'(duck_ypos), 534);
    check_eq("fly_start_x", int'(duck_xpos), xh);

    // Escape after 20 ticks: y = 536 - 40
    wait_y("escape_entry_y", 496, 200, n);
    check_eq("escape_fall_flag", int'(duck_falling), 0);
    xh = int'(duck_xpos);
    clk_step(4);
    check_eq("escape_tick_y", int'(duck_ypos), 494);
    clk_step(4);
    check_eq("escape_tick2_y", int'(duck_ypos), 492);
    check_eq("escape_x_frozen", int'(duck_xpos), xh);
    n = 0;
    while (!duck_escaped && n < 2000) begin
      clk_step(1);
      n++;
    end
    check_eq("escaped_pulse", int'(duck_escaped), 1);
    check_eq("escaped_y", int'(duck_ypos), 0);
    check_eq("escaped_vis", int'(duck_visible), 0);
    clk_step(1);
    check_eq("escaped_one_cycle", int'(duck_escaped), 0);

    // Right-wall bounce from x=958 moving right
    n = 0;
    while (!(m_lfsr[9:0] == 10'd958 && !m_lfsr[10]) && n < 70000) begin
      clk_step(1);
      n++;
    end
    check_eq("bounce_seed_found", int'(n < 70000), 1);
    spawn(ex, ed);
    check_eq("bounce_spawn_x", int'(duck_xpos), 958);
    check_eq("bounce_spawn_dir", int'(duck_dir_left), 0);
    clk_step(4);
    check_eq("bounce_wall_x", int'(duck_xpos), 960);
    check_eq("bounce_wall_dir", int'(duck_dir_left), 1);
    clk_step(4);
    check_eq("bounce_back_x", int'(duck_xpos), 958);
    game_enable = 1'b0;
    clk_step(1);
    check_eq("disable_vis", int'(duck_visible), 0);
    check_eq("disable_x_held", int'(duck_xpos), 958);
    game_enable = 1'b1;
    clk_step(1);

    // Hit at y=500, 3-tick pause, fall by 4 per tick
    spawn(ex, ed);
    wait_y("hit_reach_500", 500, 200, n);
    xh = int'(duck_xpos);
    duck_hit = 1'b1;
    clk_step(1);
    duck_hit = 1'b0;
    check_eq("hit_falling", int'(duck_falling), 1);
    check_eq("hit_vis", int'(duck_visible), 1);
    n = 1;
    while (int'(duck_ypos) == 500 && n < 100) begin
      clk_step(1);
      n++;
    end
    check_eq("hit_pause_clocks", n, 16);
    check_eq("fall_y1", int'(duck_ypos), 504);
    check_eq("fall_x_frozen", int'(duck_xpos), xh);
    for (int k = 2; k <= 8; k++) begin
      clk_step(4);
      check_eq("fall_y", int'(duck_ypos), 500 + 4 * k);
    end
    check_eq("fall_no_early_down", int'(duck_down), 0);
    clk_step(4);
    check_eq("land_y", int'(duck_ypos), 536);
    check_eq("land_down", int'(duck_down), 1);
    check_eq("land_vis", int'(duck_visible), 0);
    check_eq("land_falling", int'(duck_falling), 0);
    clk_step(1);
    check_eq("land_one_cycle", int'(duck_down), 0);

    // game_enable low during FALL
    spawn(ex, ed);
    wait_y("ge_reach_500", 500, 200, n);
    duck_hit = 1'b1;
    clk_step(1);
    duck_hit = 1'b0;
    wait_y("ge_fall_504", 504, 200, n);
    game_enable = 1'b0;
    clk_step(1);
    check_eq("ge_off_vis", int'(duck_visible), 0);
    check_eq("ge_off_falling", int'(duck_falling), 0);
    check_eq("ge_off_y_held", int'(duck_ypos), 504);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (duck_down || duck_escaped) seen = 1;
      clk_step(1);
    end
    check_eq("ge_off_no_pulse", seen, 0);
    game_enable = 1'b1;

    // Reset mid-flight
    spawn(ex, ed);
    clk_step(6);
    rst = 1'b1;
    clk_step(1);
    check_eq("midrst_x", int'(duck_xpos), 0);
    check_eq("midrst_y", int'(duck_ypos), 0);
    check_eq("midrst_vis", int'(duck_visible), 0);
    rst = 1'b0;
    clk_step(1);

    // Two hits then a fresh spawn: step grows only with the speedup option
    for (int h = 0; h < 2; h++) begin
      spawn(ex, ed);
      duck_hit = 1'b1;
      clk_step(1);
      duck_hit = 1'b0;
      game_enable = 1'b0;
      clk_step(1);
      game_enable = 1'b1;
    end
    spawn(ex, ed);
    clk_step(4);
`ifdef DUCK_SPEEDUP_EN
    check_eq("speed_y", int'(duck_ypos), 533);
`else
    check_eq("speed_y", int'(duck_ypos), 534);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
